// File: rtl/dpi_defs.sv
// dpi_defs: shared state encoding, latency limits and address-width helper for dpi burst engines
package dpi_defs;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_OE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    function automatic int adr_w(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/dpi_rd_pipe.sv
// dpi_rd_pipe: tracks issued read strobes until their data lands, RD_LAT cycles later
module dpi_rd_pipe
    import dpi_defs::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic vld_i,
    output logic pre_o,
    output logic vld_o,
    output logic empty_o
);

    logic [RD_LAT-1:0] sr_q;
    logic [RD_LAT-1:0] sr_d;
    logic [RD_LAT:0]   taps;

    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
        $error("dpi_rd_pipe: RD_LAT out of legal range");
    end

    assign taps    = {sr_q, vld_i};
    assign pre_o   = taps[RD_LAT-1];
    assign vld_o   = taps[RD_LAT];
    assign empty_o = ~|sr_q;

    // Advance every in-flight strobe one stage per cycle
    always_comb begin
        sr_d = taps[RD_LAT-1:0];
    end

    // Strobe shift register; reset discards anything in flight
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) sr_q <= '0;
        else         sr_q <= sr_d;
    end

endmodule

// File: rtl/dpi_burst_fsm.sv
// dpi_burst_fsm: bursts words from a slave-FIFO endpoint into the dpi FIFO
module dpi_burst_fsm
    import dpi_defs::*;
#(
    parameter  int DW     = 32,
    parameter  int NCH    = 2,
    parameter  int RD_LAT = 2,
    parameter  int CW     = 16,
    localparam int ADRW   = adr_w(NCH)
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            strt_i,
    input  logic [ADRW-1:0] ch_i,
    input  logic [CW-1:0]   len_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [CW-1:0]   cnt_o,
    output logic            ovf_o,
    output logic [ADRW-1:0] FIFOADR_o,
    output logic            SLCSn_o,
    output logic            SLOEn_o,
    output logic            SLRDn_o,
    input  logic            FLAG_i,
    input  logic [DW-1:0]   dpi_dt_i,
    output logic [DW-1:0]   dpi_dt_o,
    input  logic            dpi_full_i,
    input  logic            dpi_almst_full_i,
    output logic            dpi_wr_o
);

    state_t          state_q, state_d;
    logic [ADRW-1:0] ch_q, ch_d;
    logic [CW-1:0]   len_q, len_d;
    logic [CW-1:0]   issued_q, issued_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic [DW-1:0]   dt_q, dt_d;
    logic            rd_req;
    logic            cap;
    logic            pipe_empty;

    dpi_rd_pipe #(.RD_LAT(RD_LAT)) u_pipe (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .vld_i   (rd_req),
        .pre_o   (cap),
        .vld_o   (dpi_wr_o),
        .empty_o (pipe_empty)
    );

    // Next-state, read strobe and transfer bookkeeping; len of zero streams until the flag drops
    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        len_d    = len_q;
        issued_d = issued_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        rd_req   = 1'b0;
        case (state_q)
            ST_IDLE: if (strt_i) begin
                state_d  = ST_ADDR;
                ch_d     = ch_i;
                len_d    = len_i;
                issued_d = '0;
                cnt_d    = '0;
                ovf_d    = 1'b0;
            end
            ST_ADDR: state_d = ST_OE;
            ST_OE:   state_d = ST_READ;
            ST_READ: begin
                rd_req = FLAG_i && !dpi_almst_full_i &&
                         ((len_q == '0) ? (issued_q != '1) : (issued_q < len_q));
                if (rd_req) issued_d = issued_q + CW'(1);
                if ((len_q != '0) ? (rd_req && (issued_q + CW'(1) == len_q))
                                  : (!FLAG_i || issued_q == '1))
                    state_d = ST_DRAIN;
            end
            ST_DRAIN: if (pipe_empty) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (dpi_wr_o) begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
            ovf_d = ovf_q | dpi_full_i;
        end
    end

    // Capture slave data one cycle before its write strobe so both leave together
    always_comb begin
        dt_d = cap ? dpi_dt_i : dt_q;
    end

    // State and transfer registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= ST_IDLE;
            ch_q     <= '0;
            len_q    <= '0;
            issued_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            dt_q     <= '0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            len_q    <= len_d;
            issued_q <= issued_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            dt_q     <= dt_d;
        end
    end

    assign busy_o    = (state_q != ST_IDLE);
    assign done_o    = (state_q == ST_DONE);
    assign SLCSn_o   = !(state_q inside {ST_ADDR, ST_OE, ST_READ, ST_DRAIN});
    assign SLOEn_o   = !(state_q inside {ST_OE, ST_READ, ST_DRAIN});
    assign SLRDn_o   = !rd_req;
    assign FIFOADR_o = ch_q;
    assign cnt_o     = cnt_q;
    assign ovf_o     = ovf_q;
    assign dpi_dt_o  = dt_q;

endmodule

// File: tb/tb_dpi_burst_fsm.sv
// tb_dpi_burst_fsm: directed bench with a cycle-timeline reference model of the burst reader
module tb_dpi_burst_fsm;

    localparam int DW     = 32;
    localparam int NCH    = 2;
    localparam int RD_LAT = 2;
    localparam int CW     = 16;
    localparam int ADRW   = 1;
    localparam int MAXC   = (1 << CW) - 1;

    logic            clk_i = 1'b0;
    logic            rstn_i = 1'b1;
    logic            strt_i = 1'b0;
    logic [ADRW-1:0] ch_i = '0;
    logic [CW-1:0]   len_i = '0;
    logic            FLAG_i = 1'b0;
    logic [DW-1:0]   dpi_dt_i = '0;
    logic            dpi_full_i = 1'b0;
    logic            dpi_almst_full_i = 1'b0;
    logic            busy_o, done_o, ovf_o, SLCSn_o, SLOEn_o, SLRDn_o, dpi_wr_o;
    logic [CW-1:0]   cnt_o;
    logic [ADRW-1:0] FIFOADR_o;
    logic [DW-1:0]   dpi_dt_o;

    int n_chk = 0, n_err = 0, cyc = 0, tcyc = 0;
    int n_wr = 0, n_rdl = 0, n_done = 0;
    bit dt_const = 1'b0;

    dpi_burst_fsm #(.DW(DW), .NCH(NCH), .RD_LAT(RD_LAT), .CW(CW)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .strt_i(strt_i), .ch_i(ch_i), .len_i(len_i),
        .busy_o(busy_o), .done_o(done_o), .cnt_o(cnt_o), .ovf_o(ovf_o),
        .FIFOADR_o(FIFOADR_o), .SLCSn_o(SLCSn_o), .SLOEn_o(SLOEn_o), .SLRDn_o(SLRDn_o),
        .FLAG_i(FLAG_i), .dpi_dt_i(dpi_dt_i), .dpi_dt_o(dpi_dt_o),
        .dpi_full_i(dpi_full_i), .dpi_almst_full_i(dpi_almst_full_i), .dpi_wr_o(dpi_wr_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: a transfer is a timeline measured from its accept cycle
    bit m_act = 0, m_rend = 0, m_ovf = 0;
    int m_s = 0, m_rend_c = 0, m_done_c = 0, m_last = -100, m_len = 0, m_iss = 0, m_cnt = 0, m_ch = 0;
    int rdq[$];
    logic [DW-1:0] m_dt = '0, dt_prev = '0;

    always @(negedge clk_i) begin : mon
        bit acc, in_rd, e_rd, e_done, e_wr, e_end;
        int rel, d;
        if (!rstn_i) begin
            chk("rst_busy", busy_o, 0);
            chk("rst_done", done_o, 0);
            chk("rst_slcsn", SLCSn_o, 1);
            chk("rst_sloen", SLOEn_o, 1);
            chk("rst_slrdn", SLRDn_o, 1);
            chk("rst_fifoadr", FIFOADR_o, 0);
            chk("rst_wr", dpi_wr_o, 0);
            chk("rst_dt", dpi_dt_o, 0);
            chk("rst_cnt", cnt_o, 0);
            chk("rst_ovf", ovf_o, 0);
            m_act = 0; m_cnt = 0; m_ovf = 0; m_ch = 0; m_dt = '0;
            rdq.delete();
        end else begin
            rel    = cyc - m_s;
            acc    = !m_act && strt_i;
            in_rd  = m_act && rel >= 3 && !m_rend;
            e_rd   = in_rd && FLAG_i && !dpi_almst_full_i && (m_len == 0 ? m_iss != MAXC : m_iss < m_len);
            e_end  = in_rd && (m_len != 0 ? (e_rd && m_iss + 1 == m_len) : (!FLAG_i || m_iss == MAXC));
            e_done = m_act && m_rend && cyc == m_done_c;
            e_wr   = rdq.size() > 0 && rdq[0] == cyc - RD_LAT;
            if (e_wr) m_dt = dt_prev;
            chk("busy", busy_o, m_act);
            chk("done", done_o, e_done);
            chk("slcsn", SLCSn_o, !(m_act && !e_done));
            chk("sloen", SLOEn_o, !(m_act && !e_done && rel >= 2));
            chk("slrdn", SLRDn_o, !e_rd);
            chk("fifoadr", FIFOADR_o, m_ch);
            chk("wr", dpi_wr_o, e_wr);
            chk("dt", dpi_dt_o, m_dt);
            chk("cnt", cnt_o, m_cnt);
            chk("ovf", ovf_o, m_ovf);
            if (e_wr) begin
                d = rdq.pop_front();
                if (dpi_full_i) m_ovf = 1;
                if (m_cnt < MAXC) m_cnt++;
            end
            if (e_rd) begin
                rdq.push_back(cyc);
                m_iss++;
                m_last = cyc;
            end
            if (e_end) begin
                m_rend = 1;
                m_rend_c = cyc;
                d = cyc + 1;
                if (m_last + RD_LAT + 1 > d) d = m_last + RD_LAT + 1;
                m_done_c = d + 1;
            end
            if (e_done) m_act = 0;
            if (acc) begin
                m_act = 1; m_s = cyc; m_len = int'(len_i); m_ch = int'(ch_i);
                m_iss = 0; m_cnt = 0; m_ovf = 0; m_rend = 0;
            end
            if (dpi_wr_o === 1'b1) n_wr++;
            if (SLRDn_o === 1'b0) n_rdl++;
            if (done_o === 1'b1) n_done++;
        end
        dt_prev = dpi_dt_i;
        cyc++;
    end

    task automatic step();
        @(posedge clk_i);
        #1;
        tcyc++;
        dpi_dt_i = dt_const ? 32'h8000FFFF : {16'hC0DE, tcyc[15:0]};
    endtask

    task automatic start(input int ch, input int len);
        ch_i = ADRW'(ch);
        len_i = CW'(len);
        strt_i = 1'b1;
        step();
        strt_i = 1'b0;
    endtask

    task automatic wait_done(input string nm, output int steps);
        steps = -1;
        for (int i = 1; i <= 200; i++) begin
            step();
            if (done_o === 1'b1) begin
                steps = i;
                break;
            end
        end
        if (steps < 0) begin
            n_chk++;
            n_err++;
            $display("FAIL %s: no done_o within 200 cycles", nm);
        end
    endtask

    initial begin
        int st, w0, r0, d0;
        #1 rstn_i = 1'b0;
        repeat (3) step();
        chk("por_busy", busy_o, 0);
        chk("por_slcsn", SLCSn_o, 1);
        chk("por_cnt", cnt_o, 0);
        rstn_i = 1'b1;
        step();

        // basic 8-word burst from endpoint 1 with a fixed data word
        dt_const = 1'b1; FLAG_i = 1'b1;
        w0 = n_wr; r0 = n_rdl; d0 = n_done;
        start(1, 8);
        chk("t1_adr", FIFOADR_o, 1);
        chk("t1_csn", SLCSn_o, 0);
        wait_done("t1", st);
        chk("t1_lat", st, 13);
        chk("t1_cnt", cnt_o, 8);
        chk("t1_dt", dpi_dt_o, 32'h8000FFFF);
        step();
        chk("t1_wr", n_wr - w0, 8);
        chk("t1_rdl", n_rdl - r0, 8);
        chk("t1_done", n_done - d0, 1);
        chk("t1_busy", busy_o, 0);
        dt_const = 1'b0;

        // streaming mode ends when the flag drops after five reads
        w0 = n_wr;
        start(0, 0);
        repeat (7) step();
        FLAG_i = 1'b0;
        wait_done("t2", st);
        chk("t2_lat", st, RD_LAT + 1);
        chk("t2_cnt", cnt_o, 5);
        step();
        chk("t2_wr", n_wr - w0, 5);

        // almost-full stalls issuing during read cycles 4..9
        FLAG_i = 1'b1; w0 = n_wr; r0 = n_rdl;
        start(1, 16);
        repeat (5) step();
        dpi_almst_full_i = 1'b1;
        repeat (6) step();
        chk("t3_paused", n_rdl - r0, 3);
        dpi_almst_full_i = 1'b0;
        wait_done("t3", st);
        step();
        chk("t3_wr", n_wr - w0, 16);
        chk("t3_cnt", cnt_o, 16);
        chk("t3_ovf", ovf_o, 0);

        // writes into a full dpi FIFO still happen and latch overflow
        dpi_full_i = 1'b1; w0 = n_wr;
        start(0, 4);
        wait_done("t4", st);
        chk("t4_ovf_done", ovf_o, 1);
        repeat (3) step();
        chk("t4_ovf_hold", ovf_o, 1);
        chk("t4_wr", n_wr - w0, 4);
        dpi_full_i = 1'b0;

        // reset in the middle of a read burst
        start(1, 10);
        chk("t5_ovf_clr", ovf_o, 0);
        repeat (6) step();
        chk("t5_pre_cnt", cnt_o, 2);
        rstn_i = 1'b0;
        #1;
        chk("t5_rst_busy", busy_o, 0);
        chk("t5_rst_rdn", SLRDn_o, 1);
        chk("t5_rst_wr", dpi_wr_o, 0);
        chk("t5_rst_cnt", cnt_o, 0);
        chk("t5_rst_csn", SLCSn_o, 1);
        w0 = n_wr;
        repeat (2) step();
        rstn_i = 1'b1;
        repeat (4) step();
        chk("t5_no_wr", n_wr - w0, 0);

        // start pulses while busy are ignored
        d0 = n_done;
        start(1, 3);
        ch_i = 1'b0; len_i = 16'd7; strt_i = 1'b1;
        repeat (4) step();
        strt_i = 1'b0;
        wait_done("t6", st);
        chk("t6_cnt", cnt_o, 3);
        chk("t6_adr", FIFOADR_o, 1);
        step();
        chk("t6_done", n_done - d0, 1);

        // fixed length waits through flag gaps without timing out
        FLAG_i = 1'b0; w0 = n_wr; r0 = n_rdl;
        start(0, 6);
        repeat (6) step();
        FLAG_i = 1'b1;
        repeat (2) step();
        FLAG_i = 1'b0;
        repeat (3) step();
        FLAG_i = 1'b1;
        wait_done("t7", st);
        step();
        chk("t7_wr", n_wr - w0, 6);
        chk("t7_rdl", n_rdl - r0, 6);

        // single-word transfer
        start(1, 1);
        wait_done("t8", st);
        chk("t8_lat", st, 4 + RD_LAT);
        chk("t8_cnt", cnt_o, 1);

        repeat (2) step();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
